// File: rtl/branch_ctrl.sv
// Branch resolution control for the ID stage: load/ALU hazard stalls,
// operand forwarding selects, and resolved/taken branch statistics.
module branch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [2:0]  br_op,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic        ex_wr_en,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_wr_addr,
    input  logic        mem_wr_en,
    input  logic        mem_is_load,
    input  logic [4:0]  mem_wr_addr,
    input  logic        wb_wr_en,
    input  logic [4:0]  wb_wr_addr,
    input  logic        flush,
    input  logic        cmp_br,
    output logic        stall,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic [2:0]  cmp_op,
    output logic        taken,
    output logic        resolved,
    output logic [15:0] br_cnt,
    output logic [15:0] tkn_cnt
);

    typedef enum logic {IDLE, STALL} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] br_cnt_q, br_cnt_d;
    logic [15:0] tkn_cnt_q, tkn_cnt_d;

    logic        rt_used;
    logic [1:0]  need_rs, need_rt, need;
    logic        stall_c, resolve_c;

    function automatic logic [1:0] op_need(input logic [4:0] a);
        logic [1:0] n;
        n = 2'd0;
        if (a != 5'd0) begin
            if (ex_wr_en && ex_wr_addr == a)
                n = ex_is_load ? 2'd2 : 2'd1;
            else if (mem_wr_en && mem_is_load && mem_wr_addr == a)
                n = 2'd1;
        end
        return n;
    endfunction

    function automatic logic [1:0] fwd_of(input logic [4:0] a);
        logic [1:0] s;
        s = 2'b00;
        if (a != 5'd0) begin
            if (mem_wr_en && !mem_is_load && mem_wr_addr == a)
                s = 2'b01;
            else if (wb_wr_en && wb_wr_addr == a)
                s = 2'b10;
        end
        return s;
    endfunction

    always_comb begin
        rt_used = (br_op[2:1] == 2'b00);
        need_rs = op_need(rs_addr);
        need_rt = rt_used ? op_need(rt_addr) : 2'd0;
        need    = (need_rs > need_rt) ? need_rs : need_rt;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_c   = 1'b0;
        resolve_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush) begin
                    cnt_d = 2'd0;
                end else if (br_valid) begin
                    if (need == 2'd0) begin
                        resolve_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = need - 2'd1;
                        state_d = STALL;
                    end
                end
            end
            STALL: begin
                // A dropped br_valid means the branch left ID: abort like flush
                if (flush || !br_valid) begin
                    cnt_d   = 2'd0;
                    state_d = IDLE;
                end else if (cnt_q != 2'd0) begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 2'd1;
                end else begin
                    resolve_c = 1'b1;
                    state_d   = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        br_cnt_d  = br_cnt_q;
        tkn_cnt_d = tkn_cnt_q;
        if (resolve_c && br_cnt_q != 16'hFFFF)
            br_cnt_d = br_cnt_q + 16'd1;
        if (resolve_c && cmp_br && tkn_cnt_q != 16'hFFFF)
            tkn_cnt_d = tkn_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 2'd0;
            br_cnt_q  <= 16'd0;
            tkn_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            br_cnt_q  <= br_cnt_d;
            tkn_cnt_q <= tkn_cnt_d;
        end
    end

    // Pulses are combinational, so hold them low while reset is high
    assign stall     = stall_c & ~reset;
    assign resolved  = resolve_c & ~reset;
    assign taken     = resolve_c & cmp_br & ~reset;
    assign fwd_a_sel = fwd_of(rs_addr);
    assign fwd_b_sel = fwd_of(rt_addr);
    assign cmp_op    = br_op;
    assign br_cnt    = br_cnt_q;
    assign tkn_cnt   = tkn_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: per-cycle reference model plus
// directed scenarios with literal expectations.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        br_valid = 1'b0;
    logic [2:0]  br_op = 3'd0;
    logic [4:0]  rs_addr = 5'd0, rt_addr = 5'd0;
    logic        ex_wr_en = 1'b0, ex_is_load = 1'b0;
    logic [4:0]  ex_wr_addr = 5'd0;
    logic        mem_wr_en = 1'b0, mem_is_load = 1'b0;
    logic [4:0]  mem_wr_addr = 5'd0;
    logic        wb_wr_en = 1'b0;
    logic [4:0]  wb_wr_addr = 5'd0;
    logic        flush = 1'b0;
    logic        cmp_br = 1'b0;
    logic        stall, taken, resolved;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [2:0]  cmp_op;
    logic [15:0] br_cnt, tkn_cnt;

    int n_checks = 0;
    int n_fail = 0;

    branch_ctrl dut (
        .clk(clk), .reset(reset), .br_valid(br_valid), .br_op(br_op),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .ex_wr_en(ex_wr_en), .ex_is_load(ex_is_load),
        .ex_wr_addr(ex_wr_addr),
        .mem_wr_en(mem_wr_en), .mem_is_load(mem_is_load),
        .mem_wr_addr(mem_wr_addr),
        .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .flush(flush), .cmp_br(cmp_br),
        .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .cmp_op(cmp_op), .taken(taken), .resolved(resolved),
        .br_cnt(br_cnt), .tkn_cnt(tkn_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d @%0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: remaining stall cycles of the branch held in ID
    bit busy = 1'b0;
    int wait_left = 0;
    int m_br = 0, m_tk = 0;

    function automatic int reg_need(input logic [4:0] a);
        if (a == 0) return 0;
        if (ex_wr_en && ex_wr_addr == a) return ex_is_load ? 2 : 1;
        if (mem_wr_en && mem_is_load && mem_wr_addr == a) return 1;
        return 0;
    endfunction

    function automatic int need_total();
        int a, b;
        a = reg_need(rs_addr);
        b = (br_op == 3'd0 || br_op == 3'd1) ? reg_need(rt_addr) : 0;
        return (a > b) ? a : b;
    endfunction

    function automatic int fwd_exp(input logic [4:0] a);
        if (a == 0) return 0;
        if (mem_wr_en && !mem_is_load && mem_wr_addr == a) return 1;
        if (wb_wr_en && wb_wr_addr == a) return 2;
        return 0;
    endfunction

    function automatic void model_eval(output bit s, output bit r);
        s = 1'b0;
        r = 1'b0;
        if (reset || flush || !br_valid) return;
        if (!busy) begin
            if (need_total() == 0) r = 1'b1;
            else s = 1'b1;
        end else if (wait_left > 0) s = 1'b1;
        else r = 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit s, r;
        if (reset) begin
            busy = 1'b0;
            wait_left = 0;
            m_br = 0;
            m_tk = 0;
        end else begin
            model_eval(s, r);
            if (flush || !br_valid) begin
                busy = 1'b0;
            end else if (!busy && s) begin
                busy = 1'b1;
                wait_left = need_total() - 1;
            end else if (busy && s) begin
                wait_left--;
            end else if (r) begin
                busy = 1'b0;
                if (m_br < 65535) m_br++;
                if (cmp_br && m_tk < 65535) m_tk++;
            end
        end
    end

    always @(negedge clk) begin
        bit s, r;
        model_eval(s, r);
        check("m_stall", int'(stall), int'(s));
        check("m_resolved", int'(resolved), int'(r));
        check("m_taken", int'(taken), int'(r & cmp_br));
        check("m_fwd_a", int'(fwd_a_sel), fwd_exp(rs_addr));
        check("m_fwd_b", int'(fwd_b_sel), fwd_exp(rt_addr));
        check("m_cmp_op", int'(cmp_op), int'(br_op));
        check("m_br_cnt", int'(br_cnt), m_br);
        check("m_tkn_cnt", int'(tkn_cnt), m_tk);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pipe();
        ex_wr_en = 0; ex_is_load = 0; ex_wr_addr = 0;
        mem_wr_en = 0; mem_is_load = 0; mem_wr_addr = 0;
        wb_wr_en = 0; wb_wr_addr = 0;
    endtask

    task automatic chk_out(input string nm, input int s, input int r,
                           input int t);
        #2;
        check({nm, "_stall"}, int'(stall), s);
        check({nm, "_resolved"}, int'(resolved), r);
        check({nm, "_taken"}, int'(taken), t);
    endtask

    initial begin
        #2;
        check("rst_stall", int'(stall), 0);
        check("rst_br_cnt", int'(br_cnt), 0);
        check("rst_tkn_cnt", int'(tkn_cnt), 0);
        cyc();
        reset = 0;

        // beq, no hazards, taken
        br_valid = 1; br_op = 3'd0; rs_addr = 3; rt_addr = 4; cmp_br = 1;
        chk_out("beq_free", 0, 1, 1);
        cyc();
        br_valid = 0;
        #2;
        check("beq_free_br_cnt", int'(br_cnt), 1);
        check("beq_free_tkn_cnt", int'(tkn_cnt), 1);

        // bne after a load to r5: two stall cycles
        cyc();
        br_valid = 1; br_op = 3'd1; rs_addr = 5; rt_addr = 9; cmp_br = 0;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 5;
        chk_out("bne_ld_c1", 1, 0, 0);
        cyc();
        clr_pipe();
        mem_wr_en = 1; mem_is_load = 1; mem_wr_addr = 5;
        chk_out("bne_ld_c2", 1, 0, 0);
        cyc();
        clr_pipe();
        wb_wr_en = 1; wb_wr_addr = 5;
        chk_out("bne_ld_c3", 0, 1, 0);
        check("bne_ld_fwd_a", int'(fwd_a_sel), 2);
        cyc();
        br_valid = 0; clr_pipe();
        #2;
        check("bne_ld_br_cnt", int'(br_cnt), 2);
        check("bne_ld_tkn_cnt", int'(tkn_cnt), 1);

        // bgez: r0 write ignored, then unused rt hazard ignored
        cyc();
        br_valid = 1; br_op = 3'd2; rs_addr = 0; rt_addr = 7; cmp_br = 1;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 0;
        chk_out("bgez_r0", 0, 1, 1);
        cyc();
        ex_wr_addr = 7;
        chk_out("bgez_rt", 0, 1, 1);
        cyc();
        br_valid = 0; clr_pipe();
        #2;
        check("bgez_br_cnt", int'(br_cnt), 4);

        // beq after ALU write to r6: one stall, then MEM forward
        cyc();
        br_valid = 1; br_op = 3'd0; rs_addr = 6; rt_addr = 6; cmp_br = 1;
        ex_wr_en = 1; ex_is_load = 0; ex_wr_addr = 6;
        chk_out("beq_alu_c1", 1, 0, 0);
        cyc();
        clr_pipe();
        mem_wr_en = 1; mem_wr_addr = 6;
        wb_wr_en = 1; wb_wr_addr = 6;
        chk_out("beq_alu_c2", 0, 1, 1);
        check("beq_alu_fwd_a", int'(fwd_a_sel), 1);
        check("beq_alu_fwd_b", int'(fwd_b_sel), 1);
        cyc();
        br_valid = 0; clr_pipe();
        #2;
        check("beq_alu_br_cnt", int'(br_cnt), 5);
        check("beq_alu_tkn_cnt", int'(tkn_cnt), 4);

        // flush during first STALL cycle
        cyc();
        br_valid = 1; rs_addr = 8; rt_addr = 0; cmp_br = 1;
        ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 8;
        chk_out("flush_c1", 1, 0, 0);
        cyc();
        clr_pipe();
        flush = 1;
        chk_out("flush_c2", 0, 0, 0);
        cyc();
        flush = 0;
        chk_out("flush_after", 0, 1, 1);
        check("flush_br_cnt", int'(br_cnt), 5);
        cyc();

        // dropping br_valid in STALL aborts the branch
        rs_addr = 9; ex_wr_en = 1; ex_is_load = 1; ex_wr_addr = 9;
        chk_out("abort_c1", 1, 0, 0);
        cyc();
        clr_pipe();
        br_valid = 0;
        chk_out("abort_c2", 0, 0, 0);
        cyc();
        check("abort_br_cnt", int'(br_cnt), 6);

        // async reset mid-STALL
        br_valid = 1; rs_addr = 10; ex_wr_en = 1; ex_is_load = 1;
        ex_wr_addr = 10;
        cyc();
        #2;
        check("rst_mid_pre_stall", int'(stall), 1);
        reset = 1;
        #1;
        check("rst_mid_stall", int'(stall), 0);
        check("rst_mid_resolved", int'(resolved), 0);
        check("rst_mid_br_cnt", int'(br_cnt), 0);
        check("rst_mid_tkn_cnt", int'(tkn_cnt), 0);
        cyc();
        cyc();
        clr_pipe();
        br_valid = 0;
        reset = 0;

        // counter saturation
        br_valid = 1; br_op = 3'd0; rs_addr = 1; rt_addr = 2; cmp_br = 0;
        repeat (65535) cyc();
        #2;
        check("sat_br_cnt", int'(br_cnt), 65535);
        check("sat_tkn_cnt", int'(tkn_cnt), 0);
        cmp_br = 1;
        cyc();
        #2;
        check("sat_br_hold", int'(br_cnt), 65535);
        check("sat_tkn_cnt1", int'(tkn_cnt), 1);
        br_valid = 0;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
